// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bundle for serial_subtractor
interface serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Diff;
  logic         Borrow;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic         Zero;
  logic         Overflow;
`endif

  modport master (
    output start, A, B,
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    input  Zero, Overflow,
`endif
    input  busy, done, Diff, Borrow
  );

  modport slave (
    input  start, A, B,
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    output Zero, Overflow,
`endif
    output busy, done, Diff, Borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B, LSB first; SERIAL_SUBTRACTOR_FLAGS_EN adds Zero/Overflow
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_sr_q, a_sr_d;
  logic [N-1:0]   b_sr_q, b_sr_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           brw_q, brw_d;
  logic           borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
`endif

  // Full subtractor built from two half-subtractors sharing the borrow OR.
  logic         a_bit, b_bit, hs1_d, hs1_b, hs2_d, hs2_b, bout;
  logic [N-1:0] res_shift;

  assign a_bit     = a_sr_q[0];
  assign b_bit     = b_sr_q[0];
  assign hs1_d     = a_bit ^ b_bit;
  assign hs1_b     = ~a_bit & b_bit;
  assign hs2_d     = hs1_d ^ brw_q;
  assign hs2_b     = ~hs1_d & brw_q;
  assign bout      = hs1_b | hs2_b;
  assign res_shift = {hs2_d, res_q[N-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SHIFT;
          a_sr_d  = bus.A;
          b_sr_d  = bus.B;
          res_d   = '0;
          cnt_d   = '0;
          brw_d   = 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
          a_msb_d = bus.A[N-1];
          b_msb_d = bus.B[N-1];
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d = {1'b0, a_sr_q[N-1:1]};
        b_sr_d = {1'b0, b_sr_q[N-1:1]};
        res_d  = res_shift;
        brw_d  = bout;
        cnt_d  = cnt_q + CW'(1);
        // Results are published only on the last shift; they hold across later operations.
        if (cnt_q == CW'(N - 1)) begin
          state_d  = DONE;
          diff_d   = res_shift;
          borrow_d = bout;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
          zero_d   = (res_shift == '0);
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ res_shift[N-1]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
`endif
    end
  end

  assign bus.busy   = (state_q == SHIFT);
  assign bus.done   = (state_q == DONE);
  assign bus.Diff   = diff_q;
  assign bus.Borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor at N=8 and N=4
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.N(8)) if8 ();
  serial_subtractor_if #(.N(4)) if4 ();

  serial_subtractor #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference: pending shift cycles plus the arithmetic result published when they run out.
  int          m_rem  [2];
  bit          m_done [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [31:0] m_diff [2];
  bit          m_brw  [2];
  bit          m_zero [2];
  bit          m_ovf  [2];

  function automatic int width(int i);
    return (i == 0) ? 8 : 4;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int i, bit st, logic [31:0] a, logic [31:0] b);
    int n;
    int sa, sb, sr;
    logic [31:0] mask;
    n    = width(i);
    mask = (32'h1 << n) - 32'h1;
    if (rst) begin
      m_rem[i] = 0; m_done[i] = 0; m_a[i] = '0; m_b[i] = '0;
      m_diff[i] = '0; m_brw[i] = 0; m_zero[i] = 0; m_ovf[i] = 0;
    end else if (m_rem[i] > 0) begin
      m_rem[i]--;
      if (m_rem[i] == 0) begin
        m_done[i] = 1;
        m_diff[i] = (m_a[i] - m_b[i]) & mask;
        m_brw[i]  = (m_a[i] < m_b[i]);
        m_zero[i] = (m_diff[i] == 0);
        sa = m_a[i][n-1] ? int'(m_a[i]) - (1 << n) : int'(m_a[i]);
        sb = m_b[i][n-1] ? int'(m_b[i]) - (1 << n) : int'(m_b[i]);
        sr = sa - sb;
        m_ovf[i] = (sr > (1 << (n - 1)) - 1) || (sr < -(1 << (n - 1)));
      end
    end else begin
      m_done[i] = 0;
      if (st) begin
        m_rem[i] = n;
        m_a[i]   = a & mask;
        m_b[i]   = b & mask;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, if8.start, 32'(if8.A), 32'(if8.B));
    model_step(1, if4.start, 32'(if4.A), 32'(if4.B));
  end

  function automatic bit get_busy(int i);
    return (i == 0) ? if8.busy : if4.busy;
  endfunction
  function automatic bit get_done(int i);
    return (i == 0) ? if8.done : if4.done;
  endfunction
  function automatic bit get_brw(int i);
    return (i == 0) ? if8.Borrow : if4.Borrow;
  endfunction
  function automatic logic [31:0] get_diff(int i);
    return (i == 0) ? 32'(if8.Diff) : 32'(if4.Diff);
  endfunction
  function automatic logic [1:0] get_flags(int i);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    return (i == 0) ? {if8.Zero, if8.Overflow} : {if4.Zero, if4.Overflow};
`else
    return (i == 0) ? 2'b00 : 2'b00;
`endif
  endfunction
  function automatic logic [1:0] exp_flags(int i);
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    return {m_zero[i], m_ovf[i]};
`else
    return (i == 0) ? 2'b00 : 2'b00;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check((i == 0) ? "cycle_n8" : "cycle_n4",
              {27'd0, get_busy(i), get_done(i), get_brw(i), get_flags(i), get_diff(i)},
              {27'd0, m_rem[i] > 0, m_done[i], m_brw[i], exp_flags(i), m_diff[i]});
      end
    end
  end

  task automatic drive(int i, bit st, logic [31:0] a, logic [31:0] b);
    if (i == 0) begin
      if8.start = st; if8.A = a[7:0]; if8.B = b[7:0];
    end else begin
      if4.start = st; if4.A = a[3:0]; if4.B = b[3:0];
    end
  endtask

  task automatic wait_done(int i, output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      busy_cnt += int'(get_busy(i));
    end while (!get_done(i) && cyc < 40);
    if (cyc >= 40) check("done_timeout", 64'(cyc), 64'(width(i)));
  endtask

  task automatic run_op(int i, logic [31:0] a, logic [31:0] b,
                        output int lat, output int busy_cnt,
                        output logic [31:0] diff, output bit brw);
    int c, bc;
    @(negedge clk); drive(i, 1'b1, a, b);
    @(posedge clk); #1;
    bc = int'(get_busy(i));
    @(negedge clk); drive(i, 1'b0, a, b);
    wait_done(i, c, busy_cnt);
    busy_cnt += bc;
    lat  = c;
    diff = get_diff(i);
    brw  = get_brw(i);
  endtask

  int lat, bcnt, gap, dcount;
  logic [31:0] diff;
  bit brw;

  initial begin
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    check("reset_state", {get_busy(0), get_done(0), get_brw(0), get_diff(0)}, 35'd0);
    @(negedge clk) rst = 1'b0;

    run_op(0, 32'h05, 32'h03, lat, bcnt, diff, brw);
    check("lat_05_03", 64'(lat), 64'd8);
    check("busy_cycles", 64'(bcnt), 64'd8);
    check("res_05_03", {brw, diff}, {1'b0, 32'h02});

    run_op(0, 32'h03, 32'h05, lat, bcnt, diff, brw);
    check("res_03_05", {brw, diff}, {1'b1, 32'hFE});
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    check("flags_03_05", 64'(get_flags(0)), 64'd0);
`endif
    run_op(0, 32'h80, 32'h01, lat, bcnt, diff, brw);
    check("res_80_01", {brw, diff}, {1'b0, 32'h7F});
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    check("ovf_80_01", 64'(get_flags(0)), 64'd1);
`endif
    run_op(0, 32'h42, 32'h42, lat, bcnt, diff, brw);
    check("res_42_42", {brw, diff}, {1'b0, 32'h00});
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    check("zero_42_42", 64'(get_flags(0)), 64'd2);
`endif

    // start held through SHIFT with changing operands, then kept high into DONE
    @(negedge clk); drive(0, 1'b1, 32'h10, 32'h20);
    @(posedge clk); #1;
    @(negedge clk); drive(0, 1'b1, 32'hFF, 32'h00);
    wait_done(0, lat, bcnt);
    check("held_lat", 64'(lat), 64'd8);
    check("held_res", {get_brw(0), get_diff(0)}, {1'b1, 32'hF0});
    wait_done(0, gap, bcnt);
    check("done_gap", 64'(gap), 64'd9);
    check("b2b_res", {get_brw(0), get_diff(0)}, {1'b0, 32'hFF});
    @(negedge clk); drive(0, 1'b0, 32'hFF, 32'h00);

    // reset during the fourth SHIFT cycle
    @(negedge clk); drive(0, 1'b1, 32'h55, 32'h0A);
    @(posedge clk); #1;
    @(negedge clk); drive(0, 1'b0, 32'h55, 32'h0A);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_shift", {get_busy(0), get_done(0), get_brw(0), get_diff(0)}, 35'd0);
    @(negedge clk) rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      dcount += int'(get_done(0));
    end
    check("no_done_after_rst", 64'(dcount), 64'd0);
    run_op(0, 32'hFF, 32'hFF, lat, bcnt, diff, brw);
    check("res_ff_ff", {brw, diff}, {1'b0, 32'h00});

    // free-running random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive(0, ($urandom_range(0, 2) == 0), $urandom, $urandom);
      drive(1, ($urandom_range(0, 2) == 0), $urandom, $urandom);
    end
    @(negedge clk);
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (12) @(posedge clk);

    // exhaustive N=4 sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(1, 32'(a), 32'(b), lat, bcnt, diff, brw);
        check($sformatf("n4_%0d_%0d", a, b), {brw, diff},
              {(a < b), 32'((a - b) & 15)});
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
